// File: rtl/eth_frame_rx.sv
// Post-SFD Ethernet receiver: assembles 2/4/8-bit beats into bytes, filters on destination
// MAC and ethertype, checks the CRC-32 residue and delivers payload with the FCS held back.
module eth_frame_rx #(
    parameter int          DATA_WIDTH       = 2,
    parameter logic [47:0] MAC_ADDR         = 48'h000000000000,
    parameter bit          ACCEPT_BROADCAST = 1'b1,
    parameter bit          CHECK_ETHERTYPE  = 1'b0,
    parameter logic [15:0] ETHERTYPE        = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inclk,
    input  logic [DATA_WIDTH-1:0] in,
    output logic                  outclk,
    output logic [7:0]            out,
    output logic                  ethertype_outclk,
    output logic [15:0]           ethertype_out,
    output logic                  done,
    output logic                  err,
    output logic                  dropped
);
    localparam int          BEATS       = 8 / DATA_WIDTH;
    localparam logic [1:0]  BEAT_LAST   = 2'(BEATS - 1);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        S_IDLE, S_MAC_DST, S_MAC_SRC, S_ETHERTYPE, S_PAYLOAD, S_DROP
    } state_t;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DATA_WIDTH-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < DATA_WIDTH; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
        return r;
    endfunction

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    state_t      state;
    logic        wait_low;
    logic [1:0]  beat_cnt;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [7:0]  sr;
    logic        mac_ok;
    logic        bc_ok;
    logic [7:0]  et_hi;
    logic [7:0]  hb [4];
    logic [2:0]  hb_cnt;

    logic [7:0]  byte_now;
    logic        byte_done;
    logic [7:0]  mac_byte;
    logic        first_byte;
    logic        mac_ok_n;
    logic        bc_ok_n;

    always_comb begin
        byte_now   = 8'({in, sr} >> DATA_WIDTH);
        byte_done  = (beat_cnt == BEAT_LAST);
        mac_byte   = 8'(MAC_ADDR >> (6'd40 - {byte_cnt[2:0], 3'b000}));
        first_byte = (byte_cnt == 11'd0);
        mac_ok_n   = (first_byte | mac_ok) & (byte_now == mac_byte);
        bc_ok_n    = (first_byte | bc_ok) & (byte_now == 8'hFF);
    end

    always_ff @(posedge clk) begin
        outclk           <= 1'b0;
        ethertype_outclk <= 1'b0;
        done             <= 1'b0;
        if (rst) begin
            state         <= S_IDLE;
            wait_low      <= 1'b1;
            beat_cnt      <= 2'd0;
            byte_cnt      <= 11'd0;
            crc           <= CRC_INIT;
            hb_cnt        <= 3'd0;
            mac_ok        <= 1'b0;
            bc_ok         <= 1'b0;
            err           <= 1'b0;
            dropped       <= 1'b0;
            out           <= 8'h00;
            ethertype_out <= 16'h0000;
        end else if (state != S_IDLE && !inclk) begin
            done     <= 1'b1;
            err      <= (crc != CRC_RESIDUE) || (byte_cnt < 11'd18) || (beat_cnt != 2'd0);
            dropped  <= (state == S_DROP);
            state    <= S_IDLE;
            beat_cnt <= 2'd0;
            byte_cnt <= 11'd0;
            crc      <= CRC_INIT;
            hb_cnt   <= 3'd0;
        end else if (state == S_IDLE && (wait_low || !inclk)) begin
            // After an abort, the remainder of the interrupted frame is skipped.
            if (!inclk)
                wait_low <= 1'b0;
        end else begin
            crc      <= crc_step(crc, in);
            sr       <= byte_now;
            beat_cnt <= byte_done ? 2'd0 : beat_cnt + 2'd1;
            if (state == S_IDLE)
                state <= S_MAC_DST;
            if (byte_done) begin
                byte_cnt <= sat_inc(byte_cnt);
                case (state)
                    S_IDLE, S_MAC_DST: begin
                        mac_ok <= mac_ok_n;
                        bc_ok  <= bc_ok_n;
                        if (byte_cnt == 11'd5)
                            state <= (mac_ok_n || (ACCEPT_BROADCAST && bc_ok_n)) ? S_MAC_SRC : S_DROP;
                    end
                    S_MAC_SRC: begin
                        if (byte_cnt == 11'd11)
                            state <= S_ETHERTYPE;
                    end
                    S_ETHERTYPE: begin
                        if (byte_cnt == 11'd12) begin
                            et_hi <= byte_now;
                        end else begin
                            ethertype_out    <= {et_hi, byte_now};
                            ethertype_outclk <= 1'b1;
                            state <= (CHECK_ETHERTYPE && ({et_hi, byte_now} != ETHERTYPE)) ? S_DROP : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        // Four-byte holdback keeps the trailing FCS off the output.
                        if (hb_cnt == 3'd4) begin
                            out    <= hb[0];
                            outclk <= 1'b1;
                            hb[0]  <= hb[1];
                            hb[1]  <= hb[2];
                            hb[2]  <= hb[3];
                            hb[3]  <= byte_now;
                        end else begin
                            hb[hb_cnt[1:0]] <= byte_now;
                            hb_cnt          <= hb_cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eth_frame_rx.sv
// Scoreboard bench for eth_frame_rx: four instances (2/4/8-bit beats, different filters)
// share one beat driver; expected payload, ethertype and done status are queued per frame.
module tb_eth_frame_rx;
    localparam logic [47:0] OWN_MAC = 48'h020000000001;
    localparam logic [47:0] BCAST   = 48'hFFFFFFFFFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       inclk_drv;
    logic [7:0] beat_drv;
    logic [1:0] sel;

    logic        o_outclk [4];
    logic [7:0]  o_out    [4];
    logic        o_etclk  [4];
    logic [15:0] o_et     [4];
    logic        o_done   [4];
    logic        o_err    [4];
    logic        o_drop   [4];

    eth_frame_rx #(.DATA_WIDTH(2), .MAC_ADDR(OWN_MAC)) u_a (
        .clk(clk), .rst(rst), .inclk(inclk_drv && (sel == 2'd0)), .in(beat_drv[1:0]),
        .outclk(o_outclk[0]), .out(o_out[0]), .ethertype_outclk(o_etclk[0]),
        .ethertype_out(o_et[0]), .done(o_done[0]), .err(o_err[0]), .dropped(o_drop[0]));
    eth_frame_rx #(.DATA_WIDTH(8), .MAC_ADDR(OWN_MAC), .ACCEPT_BROADCAST(1'b0)) u_b (
        .clk(clk), .rst(rst), .inclk(inclk_drv && (sel == 2'd1)), .in(beat_drv),
        .outclk(o_outclk[1]), .out(o_out[1]), .ethertype_outclk(o_etclk[1]),
        .ethertype_out(o_et[1]), .done(o_done[1]), .err(o_err[1]), .dropped(o_drop[1]));
    eth_frame_rx #(.DATA_WIDTH(8), .MAC_ADDR(OWN_MAC), .ACCEPT_BROADCAST(1'b1)) u_c (
        .clk(clk), .rst(rst), .inclk(inclk_drv && (sel == 2'd2)), .in(beat_drv),
        .outclk(o_outclk[2]), .out(o_out[2]), .ethertype_outclk(o_etclk[2]),
        .ethertype_out(o_et[2]), .done(o_done[2]), .err(o_err[2]), .dropped(o_drop[2]));
    eth_frame_rx #(.DATA_WIDTH(4), .MAC_ADDR(OWN_MAC), .CHECK_ETHERTYPE(1'b1),
                   .ETHERTYPE(16'h88B5)) u_d (
        .clk(clk), .rst(rst), .inclk(inclk_drv && (sel == 2'd3)), .in(beat_drv[3:0]),
        .outclk(o_outclk[3]), .out(o_out[3]), .ethertype_outclk(o_etclk[3]),
        .ethertype_out(o_et[3]), .done(o_done[3]), .err(o_err[3]), .dropped(o_drop[3]));

    logic        m_outclk, m_etclk, m_done, m_err, m_drop;
    logic [7:0]  m_out;
    logic [15:0] m_et;
    always_comb begin
        m_outclk = o_outclk[sel];
        m_out    = o_out[sel];
        m_etclk  = o_etclk[sel];
        m_et     = o_et[sel];
        m_done   = o_done[sel];
        m_err    = o_err[sel];
        m_drop   = o_drop[sel];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [7:0]  frm [$];
    logic [7:0]  pay [$];
    logic [7:0]  exp_bytes [$];
    logic [15:0] exp_et [$];
    logic [1:0]  exp_done [$];   // {err, dropped}

    always @(negedge clk) begin
        if (m_outclk) begin
            if (exp_bytes.size() == 0) chk("unexpected_outclk", 32'd1, 32'd0);
            else chk("out_byte", {24'h0, m_out}, {24'h0, exp_bytes.pop_front()});
        end
        if (m_etclk) begin
            if (exp_et.size() == 0) chk("unexpected_ethertype_outclk", 32'd1, 32'd0);
            else chk("ethertype_out", {16'h0, m_et}, {16'h0, exp_et.pop_front()});
        end
        if (m_done) begin
            if (exp_done.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                logic [1:0] e;
                e = exp_done.pop_front();
                chk("err", {31'h0, m_err}, {31'h0, e[1]});
                chk("dropped", {31'h0, m_drop}, {31'h0, e[0]});
            end
        end
    end

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [15:0] et, input int npl, input bit rnd);
        logic [31:0] f;
        frm.delete();
        pay.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'(8'h10 + i));
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        for (int i = 0; i < npl; i++) begin
            logic [7:0] v;
            v = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
            frm.push_back(v);
            pay.push_back(v);
        end
        f = fcs_of(frm.size());
        frm.push_back(f[7:0]);
        frm.push_back(f[15:8]);
        frm.push_back(f[23:16]);
        frm.push_back(f[31:24]);
    endtask

    task automatic expect_payload(input int n);
        for (int i = 0; i < n; i++) exp_bytes.push_back(pay[i]);
    endtask

    // Drives frm (or its first 'cut' beats), optionally pulsing rst on beat 'rst_beat'.
    task automatic send(input int dw, input int cut, input int rst_beat);
        int bpb;
        int total;
        bpb   = 8 / dw;
        total = (cut >= 0) ? cut : frm.size() * bpb;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            inclk_drv = 1'b1;
            beat_drv  = 8'((32'(frm[k / bpb]) >> ((k % bpb) * dw)) & ((32'd1 << dw) - 32'd1));
            rst       = (k == rst_beat);
        end
        @(negedge clk);
        inclk_drv = 1'b0;
        beat_drv  = 8'h00;
        rst       = 1'b0;
        repeat (6) @(negedge clk);
        chk("done_pending", exp_done.size(), 0);
        chk("bytes_pending", exp_bytes.size(), 0);
        chk("ethertype_pending", exp_et.size(), 0);
        exp_done.delete();
        exp_bytes.delete();
        exp_et.delete();
    endtask

    initial begin
        rst       = 1'b1;
        inclk_drv = 1'b0;
        beat_drv  = 8'h00;
        sel       = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_outclk", {31'h0, m_outclk}, 32'd0);
            chk("rst_out", {24'h0, m_out}, 32'd0);
            chk("rst_etclk", {31'h0, m_etclk}, 32'd0);
            chk("rst_ethertype_out", {16'h0, m_et}, 32'd0);
            chk("rst_done", {31'h0, m_done}, 32'd0);
            chk("rst_err", {31'h0, m_err}, 32'd0);
            chk("rst_dropped", {31'h0, m_drop}, 32'd0);
        end

        // 2-bit unicast, 46-byte counting payload, good FCS
        sel = 2'd0;
        build(OWN_MAC, 16'h0800, 46, 1'b0);
        expect_payload(46); exp_et.push_back(16'h0800); exp_done.push_back(2'b00);
        send(2, -1, -1);

        // same frame with one FCS bit flipped
        frm[frm.size() - 1] ^= 8'h10;
        expect_payload(46); exp_et.push_back(16'h0800); exp_done.push_back(2'b10);
        send(2, -1, -1);

        // 8-bit broadcast with broadcast rejected, then accepted
        sel = 2'd1;
        build(BCAST, 16'h0800, 46, 1'b1);
        exp_done.push_back(2'b01);
        send(8, -1, -1);
        sel = 2'd2;
        expect_payload(46); exp_et.push_back(16'h0800); exp_done.push_back(2'b00);
        send(8, -1, -1);

        // 4-bit with ethertype filter: mismatching and matching ethertype
        sel = 2'd3;
        build(OWN_MAC, 16'h0800, 46, 1'b1);
        exp_et.push_back(16'h0800); exp_done.push_back(2'b01);
        send(4, -1, -1);
        build(OWN_MAC, 16'h88B5, 50, 1'b1);
        expect_payload(50); exp_et.push_back(16'h88B5); exp_done.push_back(2'b00);
        send(4, -1, -1);

        // unicast to another station is dropped
        sel = 2'd0;
        build(48'h020000000002, 16'h0800, 46, 1'b0);
        exp_done.push_back(2'b01);
        send(2, -1, -1);

        // frame cut after 3 beats of byte 20: partial byte
        build(OWN_MAC, 16'h0800, 46, 1'b0);
        expect_payload(2); exp_et.push_back(16'h0800); exp_done.push_back(2'b10);
        send(2, 20 * 4 + 3, -1);

        // minimum 18-byte frame is good; 17 bytes is an error
        build(OWN_MAC, 16'h0800, 0, 1'b0);
        exp_et.push_back(16'h0800); exp_done.push_back(2'b00);
        send(2, -1, -1);
        void'(frm.pop_back());
        exp_et.push_back(16'h0800); exp_done.push_back(2'b10);
        send(2, -1, -1);

        // rst at payload byte 10, inclk held 20 more cycles: no done
        build(OWN_MAC, 16'h0800, 46, 1'b0);
        expect_payload(6); exp_et.push_back(16'h0800);
        send(2, 24 * 4 + 21, 24 * 4);

        // next frame after the abort is received normally
        build(OWN_MAC, 16'h0800, 60, 1'b1);
        expect_payload(60); exp_et.push_back(16'h0800); exp_done.push_back(2'b00);
        send(2, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
